mfm_id_framer: RTL and testbench
================================

Name: mfm_id_framer

Overview:
- Sits directly downstream of the MFM DPLL/decoder pair and runs in the clk_50 domain.
- Consumes the recovered MFM cell stream, one cell per strobe, and hunts for the A1 address mark (missing-clock raw pattern 16'h4489).
- After a mark it frames bytes and decodes the ST412/WD1010 ID field (mark byte, cylinder, head, sector, CRC), checks CRC-CCITT and presents the sector address to the controller.
- Data marks and framing violations are flagged so the controller can re-arm.

Parameters:
- MARK_PATTERN, 16'h4489, raw MFM cell pattern of the A1 address mark.
- CRC_POLY, 16'h1021, CRC-CCITT polynomial.
- CRC_PRESET, 16'hFFFF, CRC preset applied before the A1 byte.

Ports:
- clk_50  input  1  50 MHz system clock
- reset  input  1  asynchronous, active-high reset
- bit_strobe  input  1  one-clk_50 pulse per MFM cell (each clk_5 edge)
- mfm_cell  input  1  cell value, valid when bit_strobe=1
- in_sync  output  1  high from mark detection until the field completes or aborts
- id_valid  output  1  one-cycle pulse: ID field complete
- id_crc_ok  output  1  CRC result, valid with id_valid; held until next id_valid
- cylinder  output  10  cylinder; held until next id_valid
- head  output  3  head number
- sector  output  8  sector number
- bad_block  output  1  head byte bit 7
- data_mark  output  1  one-cycle pulse: A1 followed by F8 or FB
- sync_lost  output  1  one-cycle pulse: framing aborted

Behaviour:
- Reset is asynchronous and active-high; the design has one clock, clk_50.
- Reset values: every output 0; state HUNT; shift register 0; cell counter 0; CRC set to CRC_PRESET.
- Cell shift register is 16 bits wide. On bit_strobe, shift left and load mfm_cell into bit 0. Nothing advances without bit_strobe.
- HUNT:
  - When the post-shift register equals MARK_PATTERN, go to MARK.
  - Load the CRC with CRC_A1, the package constant equal to CRC_PRESET after processing 8'hA1 MSB-first.
  - Clear the cell counter and raise in_sync in the next cycle.
- Byte framing:
  - Count 16 strobes per byte.
  - Data byte = register bits {14,12,10,8,6,4,2,0} at count 15, MSB first.
  - Each data cell (odd cell count) updates the CRC serially, MSB-first, with CRC_POLY.
- MARK, on byte complete:
  - FE/FF/FC/FD: store cylinder[9:8] as 0/1/2/3 respectively; go to HDR.
  - F8/FB: pulse data_mark; go to HUNT.
  - A1 with the raw register equal to MARK_PATTERN (repeated mark): reload CRC_A1; stay in MARK.
  - Anything else: pulse sync_lost; go to HUNT.
- HDR:
  - Capture three bytes in order: cylinder[7:0], head byte (head=bits 2:0, bad_block=bit 7), sector.
  - Then go to CRCB.
- CRCB:
  - Clock two more bytes through the CRC.
  - On completion, pulse id_valid. Set id_crc_ok=1 iff the CRC register is 16'h0000.
  - Update cylinder, head, sector, bad_block in the same cycle from shadow registers, so the outputs change only on id_valid.
  - Go to HUNT.
- Framing violation: in MARK, HDR or CRCB, two consecutive 1 cells (register bits [1:0]==2'b11 after a shift). Pulse sync_lost, go to HUNT, leave held outputs unchanged.
- in_sync: high in MARK, HDR and CRCB; low in HUNT. It drops in the same cycle as the id_valid, data_mark or sync_lost pulse.
- Latency: id_valid, data_mark and sync_lost pulse exactly one clk_50 after the strobe that completes the byte or detects the violation.
- Reset mid-field: immediate return to HUNT. No pulses are emitted and held outputs clear to 0.
- The mark pattern appearing inside HDR or CRCB is not re-detected; bytes are framed by count only.

Decomposition:
- Package mfm_pkg holds:
  - state enum (HUNT, MARK, HDR, CRCB);
  - MARK_PATTERN, CRC_POLY, CRC_PRESET;
  - CRC_A1 constant and a crc_ccitt_bit function;
  - ID mark byte constants (FE, FF, FC, FD) and data mark constants (F8, FB).
- Sub-module mfm_crc16 holds the serial CRC register, with preset, load and step inputs. All other logic lives in one module.

Test Plan:
- Clean ID: cells for A1(4489), FE, 8'h23, 8'h02, 8'h11 and a correct CRC -> one id_valid; cylinder=35, head=2, sector=17, bad_block=0, id_crc_ok=1; in_sync high for 96 strobes.
- High cylinder: ID mark FD, cyl byte 8'hFF, head byte 8'h85 -> cylinder=1023, head=5, bad_block=1.
- CRC error: same as the clean ID with the last CRC byte bit 0 flipped -> id_valid with id_crc_ok=0; the held fields still update.
- Data mark: A1 then FB -> data_mark pulse one cycle after the 32nd strobe after the mark; no id_valid; state HUNT.
- Violation: A1, FE, then cells "11" inside the cylinder byte -> sync_lost; previously held cylinder, head and sector unchanged; the next valid ID is decoded normally.
- Reset mid-HDR plus gapped strobes: assert reset during the head byte -> all outputs 0 asynchronously. With bit_strobe held low for 100 cycles, the state does not advance.

Source files
------------

// File: rtl/mfm_pkg.sv
// Shared types and constants for the MFM ID-field framer: FSM states, the A1
// missing-clock mark, CRC-CCITT parameters and the ID/data mark byte values.
package mfm_pkg;

   typedef enum logic [1:0] {
      HUNT,
      MARK,
      HDR,
      CRCB
   } state_t;

   localparam logic [15:0] MARK_PATTERN = 16'h4489;
   localparam logic [15:0] CRC_POLY     = 16'h1021;
   localparam logic [15:0] CRC_PRESET   = 16'hFFFF;

   // CRC_PRESET after 8'hA1 has been clocked through MSB-first.
   localparam logic [15:0] CRC_A1       = 16'h443B;

   localparam logic [7:0]  BYTE_A1      = 8'hA1;
   localparam logic [7:0]  ID_MARK_FE   = 8'hFE;
   localparam logic [7:0]  ID_MARK_FF   = 8'hFF;
   localparam logic [7:0]  ID_MARK_FC   = 8'hFC;
   localparam logic [7:0]  ID_MARK_FD   = 8'hFD;
   localparam logic [7:0]  DATA_MARK_F8 = 8'hF8;
   localparam logic [7:0]  DATA_MARK_FB = 8'hFB;

   function automatic logic [15:0] crc_ccitt_bit(input logic [15:0] crc, input logic din);
      crc_ccitt_bit = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/mfm_crc16.sv
// Serial CRC-CCITT register: preset, load with the post-A1 value, or step one
// data bit MSB-first. Also exposes the value one step ahead for end-of-field checks.
module mfm_crc16
   import mfm_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_preset,
   input  logic        i_load,
   input  logic        i_step,
   input  logic        i_bit,
   output logic [15:0] o_crc_stepped
);

   logic [15:0] r_crc;
   logic [15:0] w_stepped;

   assign w_stepped     = crc_ccitt_bit(r_crc, i_bit);
   assign o_crc_stepped = w_stepped;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_crc <= CRC_PRESET;
      else if (i_preset) r_crc <= CRC_PRESET;
      else if (i_load)   r_crc <= CRC_A1;
      else if (i_step)   r_crc <= w_stepped;
   end

endmodule

// File: rtl/mfm_id_framer.sv
// Hunts the A1 address mark in the recovered MFM cell stream, frames bytes and
// decodes the ID field (mark, cylinder, head, sector, CRC) for the controller.
module mfm_id_framer
   import mfm_pkg::*;
(
   input  logic       clk_50,
   input  logic       reset,
   input  logic       bit_strobe,
   input  logic       mfm_cell,
   output logic       in_sync,
   output logic       id_valid,
   output logic       id_crc_ok,
   output logic [9:0] cylinder,
   output logic [2:0] head,
   output logic [7:0] sector,
   output logic       bad_block,
   output logic       data_mark,
   output logic       sync_lost
);

   state_t      r_state, w_state_next;
   // Only 15 cells are stored; the 16-bit post-shift word is formed combinationally.
   logic [14:0] r_shift;
   logic [3:0]  r_cnt;
   logic [1:0]  r_byte_idx, w_byte_idx_next;
   logic [1:0]  r_cyl_hi_sh, w_cyl_hi;
   logic [7:0]  r_cyl_lo_sh, r_sec_sh;
   logic [2:0]  r_head_sh;
   logic        r_bad_sh;
   logic        r_id_valid, r_id_crc_ok, r_data_mark, r_sync_lost, r_bad_block;
   logic [9:0]  r_cylinder;
   logic [2:0]  r_head;
   logic [7:0]  r_sector;

   logic [15:0] w_shift, w_crc_stepped;
   logic [7:0]  w_byte;
   logic        w_mark_hit, w_byte_done, w_viol;
   logic        w_crc_preset, w_crc_load, w_crc_step;
   logic        w_id_valid, w_data_mark, w_sync_lost;
   logic        w_cap_cyl_hi, w_cap_cyl_lo, w_cap_head, w_cap_sec;

   assign w_shift     = {r_shift, mfm_cell};
   assign w_byte      = {w_shift[14], w_shift[12], w_shift[10], w_shift[8],
                         w_shift[6],  w_shift[4],  w_shift[2],  w_shift[0]};
   assign w_mark_hit  = bit_strobe && (r_state == HUNT) && (w_shift == MARK_PATTERN);
   assign w_byte_done = bit_strobe && (r_cnt == 4'd15);
   assign w_viol      = bit_strobe && (r_state != HUNT) && (w_shift[1:0] == 2'b11);
   assign w_crc_step  = bit_strobe && (r_state != HUNT) && r_cnt[0];

   mfm_crc16 u_crc (
      .i_clk         (clk_50),
      .i_rst         (reset),
      .i_preset      (w_crc_preset),
      .i_load        (w_crc_load),
      .i_step        (w_crc_step),
      .i_bit         (mfm_cell),
      .o_crc_stepped (w_crc_stepped)
   );

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) r_state <= HUNT;
      else       r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      w_state_next    = r_state;
      w_byte_idx_next = r_byte_idx;
      w_crc_preset    = 1'b0;
      w_crc_load      = 1'b0;
      w_id_valid      = 1'b0;
      w_data_mark     = 1'b0;
      w_sync_lost     = 1'b0;
      w_cap_cyl_hi    = 1'b0;
      w_cap_cyl_lo    = 1'b0;
      w_cap_head      = 1'b0;
      w_cap_sec       = 1'b0;
      w_cyl_hi        = 2'd0;
      if (r_state == HUNT) begin
         if (w_mark_hit) begin
            w_state_next = MARK;
            w_crc_load   = 1'b1;
         end
      end else if (w_viol) begin
         w_sync_lost  = 1'b1;
         w_state_next = HUNT;
         w_crc_preset = 1'b1;
      end else if (w_byte_done) begin
         case (r_state)
            MARK: begin
               w_byte_idx_next = 2'd0;
               case (w_byte)
                  ID_MARK_FE: begin w_cap_cyl_hi = 1'b1; w_cyl_hi = 2'd0; w_state_next = HDR; end
                  ID_MARK_FF: begin w_cap_cyl_hi = 1'b1; w_cyl_hi = 2'd1; w_state_next = HDR; end
                  ID_MARK_FC: begin w_cap_cyl_hi = 1'b1; w_cyl_hi = 2'd2; w_state_next = HDR; end
                  ID_MARK_FD: begin w_cap_cyl_hi = 1'b1; w_cyl_hi = 2'd3; w_state_next = HDR; end
                  DATA_MARK_F8, DATA_MARK_FB: begin
                     w_data_mark  = 1'b1;
                     w_state_next = HUNT;
                     w_crc_preset = 1'b1;
                  end
                  BYTE_A1: begin
                     if (w_shift == MARK_PATTERN) begin
                        w_crc_load = 1'b1;
                     end else begin
                        w_sync_lost  = 1'b1;
                        w_state_next = HUNT;
                        w_crc_preset = 1'b1;
                     end
                  end
                  default: begin
                     w_sync_lost  = 1'b1;
                     w_state_next = HUNT;
                     w_crc_preset = 1'b1;
                  end
               endcase
            end
            HDR: begin
               case (r_byte_idx)
                  2'd0:    w_cap_cyl_lo = 1'b1;
                  2'd1:    w_cap_head   = 1'b1;
                  default: w_cap_sec    = 1'b1;
               endcase
               if (r_byte_idx == 2'd2) begin
                  w_state_next    = CRCB;
                  w_byte_idx_next = 2'd0;
               end else begin
                  w_byte_idx_next = r_byte_idx + 2'd1;
               end
            end
            CRCB: begin
               if (r_byte_idx == 2'd1) begin
                  w_id_valid      = 1'b1;
                  w_state_next    = HUNT;
                  w_crc_preset    = 1'b1;
                  w_byte_idx_next = 2'd0;
               end else begin
                  w_byte_idx_next = 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         r_shift     <= '0;
         r_cnt       <= '0;
         r_byte_idx  <= '0;
         r_cyl_hi_sh <= '0;
         r_cyl_lo_sh <= '0;
         r_head_sh   <= '0;
         r_bad_sh    <= 1'b0;
         r_sec_sh    <= '0;
         r_id_valid  <= 1'b0;
         r_data_mark <= 1'b0;
         r_sync_lost <= 1'b0;
         r_id_crc_ok <= 1'b0;
         r_cylinder  <= '0;
         r_head      <= '0;
         r_sector    <= '0;
         r_bad_block <= 1'b0;
      end else begin
         r_byte_idx  <= w_byte_idx_next;
         r_id_valid  <= w_id_valid;
         r_data_mark <= w_data_mark;
         r_sync_lost <= w_sync_lost;
         if (bit_strobe) begin
            r_shift <= w_shift[14:0];
            r_cnt   <= (r_state == HUNT) ? 4'd0 : r_cnt + 4'd1;
         end
         if (w_cap_cyl_hi) r_cyl_hi_sh <= w_cyl_hi;
         if (w_cap_cyl_lo) r_cyl_lo_sh <= w_byte;
         if (w_cap_head) begin
            r_head_sh <= w_byte[2:0];
            r_bad_sh  <= w_byte[7];
         end
         if (w_cap_sec) r_sec_sh <= w_byte;
         // Held fields move only together with the id_valid pulse.
         if (w_id_valid) begin
            r_id_crc_ok <= (w_crc_stepped == 16'h0000);
            r_cylinder  <= {r_cyl_hi_sh, r_cyl_lo_sh};
            r_head      <= r_head_sh;
            r_sector    <= r_sec_sh;
            r_bad_block <= r_bad_sh;
         end
      end
   end

   assign in_sync   = (r_state != HUNT);
   assign id_valid  = r_id_valid;
   assign id_crc_ok = r_id_crc_ok;
   assign cylinder  = r_cylinder;
   assign head      = r_head;
   assign sector    = r_sector;
   assign bad_block = r_bad_block;
   assign data_mark = r_data_mark;
   assign sync_lost = r_sync_lost;

endmodule

// File: tb/tb_mfm_id_framer.sv
// Directed bench for mfm_id_framer: table of ID fields encoded to MFM cells,
// plus hand sequences for data marks, framing violations, reset and stalls.
module tb_mfm_id_framer;

   logic       clk_50 = 1'b0;
   logic       reset;
   logic       bit_strobe;
   logic       mfm_cell;
   logic       in_sync, id_valid, id_crc_ok, bad_block, data_mark, sync_lost;
   logic [9:0] cylinder;
   logic [2:0] head;
   logic [7:0] sector;

   mfm_id_framer dut (
      .clk_50     (clk_50),
      .reset      (reset),
      .bit_strobe (bit_strobe),
      .mfm_cell   (mfm_cell),
      .in_sync    (in_sync),
      .id_valid   (id_valid),
      .id_crc_ok  (id_crc_ok),
      .cylinder   (cylinder),
      .head       (head),
      .sector     (sector),
      .bad_block  (bad_block),
      .data_mark  (data_mark),
      .sync_lost  (sync_lost)
   );

   always #10 clk_50 = ~clk_50;

   typedef struct {
      logic [7:0] am;
      logic [7:0] cyl;
      logic [7:0] hb;
      logic [7:0] sec;
      logic       corrupt;
      int         n_marks;
      logic [9:0] e_cyl;
      logic [2:0] e_head;
      logic       e_bad;
      logic       e_crc_ok;
   } vec_t;

   vec_t vecs[5];

   int   n_pass = 0;
   int   n_total = 0;
   int   strobe_n = 0;
   int   sync_strobes = 0;
   logic prev_bit = 1'b0;

   int   n_idv = 0, n_dm = 0, n_sl = 0;
   int   idv_at = 0, dm_at = 0, sl_at = 0;

   // Pulses are seen on the falling edge right after the strobe's rising edge.
   always @(negedge clk_50) begin
      if (id_valid)  begin n_idv++; idv_at = strobe_n; end
      if (data_mark) begin n_dm++;  dm_at  = strobe_n; end
      if (sync_lost) begin n_sl++;  sl_at  = strobe_n; end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--)
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      return r;
   endfunction

   task automatic send_cell(input logic b);
      @(negedge clk_50);
      if (in_sync) sync_strobes++;
      bit_strobe = 1'b1;
      mfm_cell   = b;
      strobe_n++;
      @(negedge clk_50);
      bit_strobe = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         send_cell(~prev_bit & ~d[i]);
         send_cell(d[i]);
         prev_bit = d[i];
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_bits(d, 8);
   endtask

   task automatic send_mark();
      logic [15:0] m;
      m = 16'h4489;
      for (int i = 15; i >= 0; i--) send_cell(m[i]);
      prev_bit = 1'b1;
   endtask

   task automatic send_preamble();
      prev_bit = 1'b0;
      send_byte(8'h00);
      send_byte(8'h00);
   endtask

   task automatic run_vec(input vec_t v, input int gap, input string tag);
      int          b_idv, b_sl, b_dm, b_sync, mark_end;
      logic [15:0] c;
      c = crc_byte(16'hFFFF, 8'hA1);
      c = crc_byte(c, v.am);
      c = crc_byte(c, v.cyl);
      c = crc_byte(c, v.hb);
      c = crc_byte(c, v.sec);
      if (v.corrupt) c[0] = ~c[0];
      b_idv = n_idv; b_sl = n_sl; b_dm = n_dm;
      send_preamble();
      b_sync = sync_strobes;
      for (int k = 0; k < v.n_marks; k++) send_mark();
      mark_end = strobe_n;
      if (gap > 0) begin
         repeat (gap) @(negedge clk_50);
         check({tag, " in_sync held over stall"}, in_sync, 1);
         check({tag, " no id_valid over stall"}, n_idv - b_idv, 0);
      end
      send_byte(v.am);
      send_byte(v.cyl);
      send_byte(v.hb);
      send_byte(v.sec);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      send_byte(8'h00);
      check({tag, " id_valid count"}, n_idv - b_idv, 1);
      check({tag, " id_valid strobe"}, idv_at, mark_end + 96);
      check({tag, " cylinder"}, cylinder, v.e_cyl);
      check({tag, " head"}, head, v.e_head);
      check({tag, " sector"}, sector, v.sec);
      check({tag, " bad_block"}, bad_block, v.e_bad);
      check({tag, " id_crc_ok"}, id_crc_ok, v.e_crc_ok);
      check({tag, " in_sync strobes"}, sync_strobes - b_sync, 96 + 16 * (v.n_marks - 1));
      check({tag, " no sync_lost"}, n_sl - b_sl, 0);
      check({tag, " no data_mark"}, n_dm - b_dm, 0);
      check({tag, " in_sync low after"}, in_sync, 0);
   endtask

   // Mark followed by one byte that ends the frame: data mark or bad mark byte.
   task automatic mark_then_byte(input logic [7:0] b, input int e_dm, input int e_sl, input string tag);
      int b_idv, b_sl, b_dm, mark_start;
      b_idv = n_idv; b_sl = n_sl; b_dm = n_dm;
      send_preamble();
      mark_start = strobe_n;
      send_mark();
      send_byte(b);
      send_byte(8'h00);
      check({tag, " data_mark count"}, n_dm - b_dm, e_dm);
      check({tag, " sync_lost count"}, n_sl - b_sl, e_sl);
      if (e_dm != 0) check({tag, " data_mark strobe"}, dm_at, mark_start + 32);
      if (e_sl != 0) check({tag, " sync_lost strobe"}, sl_at, mark_start + 32);
      check({tag, " no id_valid"}, n_idv - b_idv, 0);
      check({tag, " in_sync low"}, in_sync, 0);
   endtask

   logic [7:0] dm_bytes[2];

   initial begin
      int b_idv, b_sl, b_dm, exp_sl;
      reset      = 1'b1;
      bit_strobe = 1'b0;
      mfm_cell   = 1'b0;

      vecs[0] = '{8'hFE, 8'h23, 8'h02, 8'h11, 1'b0, 1, 10'd35,   3'd2, 1'b0, 1'b1};
      vecs[1] = '{8'hFD, 8'hFF, 8'h85, 8'h07, 1'b0, 1, 10'd1023, 3'd5, 1'b1, 1'b1};
      vecs[2] = '{8'hFE, 8'h23, 8'h02, 8'h11, 1'b1, 1, 10'd35,   3'd2, 1'b0, 1'b0};
      vecs[3] = '{8'hFC, 8'h4A, 8'h03, 8'hC8, 1'b0, 2, 10'd586,  3'd3, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 8'h00, 8'h80, 8'h01, 1'b0, 1, 10'd256,  3'd0, 1'b1, 1'b1};
      dm_bytes[0] = 8'hFB;
      dm_bytes[1] = 8'hF8;

      repeat (3) @(negedge clk_50);
      check("reset in_sync", in_sync, 0);
      check("reset id_valid", id_valid, 0);
      check("reset id_crc_ok", id_crc_ok, 0);
      check("reset cylinder", cylinder, 0);
      check("reset head", head, 0);
      check("reset sector", sector, 0);
      check("reset bad_block", bad_block, 0);
      check("reset data_mark", data_mark, 0);
      check("reset sync_lost", sync_lost, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk_50);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

      for (int i = 0; i < 2; i++) mark_then_byte(dm_bytes[i], 1, 0, $sformatf("dm%0d", i));
      mark_then_byte(8'h12, 0, 1, "bad_mark_byte");

      // Two consecutive 1 cells inside the cylinder byte.
      b_idv = n_idv; b_sl = n_sl; b_dm = n_dm;
      send_preamble();
      send_mark();
      send_byte(8'hFE);
      send_cell(1'b0);
      send_cell(1'b1);
      send_cell(1'b1);
      exp_sl = strobe_n;
      send_byte(8'h00);
      check("viol sync_lost count", n_sl - b_sl, 1);
      check("viol sync_lost strobe", sl_at, exp_sl);
      check("viol no id_valid", n_idv - b_idv, 0);
      check("viol no data_mark", n_dm - b_dm, 0);
      check("viol in_sync low", in_sync, 0);
      check("viol cylinder held", cylinder, vecs[4].e_cyl);
      check("viol head held", head, vecs[4].e_head);
      check("viol sector held", sector, vecs[4].sec);
      check("viol bad_block held", bad_block, vecs[4].e_bad);
      run_vec(vecs[0], 0, "post_viol");

      // Asynchronous reset in the middle of the head byte.
      b_idv = n_idv; b_sl = n_sl; b_dm = n_dm;
      send_preamble();
      send_mark();
      send_byte(8'hFE);
      send_byte(8'h23);
      send_bits(8'h02, 4);
      check("mid_hdr in_sync before reset", in_sync, 1);
      @(negedge clk_50);
      #3 reset = 1'b1;
      #1;
      check("async reset in_sync", in_sync, 0);
      check("async reset cylinder", cylinder, 0);
      check("async reset head", head, 0);
      check("async reset sector", sector, 0);
      check("async reset bad_block", bad_block, 0);
      check("async reset id_crc_ok", id_crc_ok, 0);
      repeat (2) @(negedge clk_50);
      reset = 1'b0;
      repeat (2) @(negedge clk_50);
      check("reset no id_valid", n_idv - b_idv, 0);
      check("reset no sync_lost", n_sl - b_sl, 0);
      check("reset no data_mark", n_dm - b_dm, 0);

      run_vec(vecs[1], 100, "stall");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
